// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Holds the arbiter FSM state encoding, the per-requester SPI mode encoding
// and small helpers that decode which directions a mode uses.
package spi_arb_pkg;

  localparam int SPI_MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARB       = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  typedef enum logic [SPI_MODE_W-1:0] {
    SPI_MODE_NONE = 2'd0,
    SPI_MODE_TX   = 2'd1,
    SPI_MODE_RX   = 2'd2,
    SPI_MODE_FD   = 2'd3
  } spi_mode_e;

  // True when the mode needs the master's transmit side to finish.
  function automatic logic mode_has_tx(spi_mode_e m);
    return (m == SPI_MODE_TX) || (m == SPI_MODE_FD);
  endfunction

  // True when the mode needs the master's receive side to finish.
  function automatic logic mode_has_rx(spi_mode_e m);
    return (m == SPI_MODE_RX) || (m == SPI_MODE_FD);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: the search starts at last_grant+1 and
// wraps modulo NUM_REQ; the first requesting index wins. Only loop
// variables are used as bit indices so every select is static.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found_s;

  // Scan offsets 1..NUM_REQ from the previous winner, first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found_s && req[j] && (j == ((int'(last_grant) + 1 + k) % NUM_REQ))) begin
          found_s   = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master between NUM_REQ requesters. A round-robin winner
// is accepted with a one-cycle req_ready pulse, its mode/data are held on
// spi_req/spi_din until the master reports the needed done strobes, then a
// one-cycle rsp_valid reports the result and a GAP of idle cycles follows.
// Optional build macro: SPI_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles with rsp_err set.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SPI_TRF_BIT    = 8,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [SPI_MODE_W*NUM_REQ-1:0]    req_mode,
  input  logic [SPI_TRF_BIT*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [SPI_TRF_BIT-1:0]           rsp_data,
  output logic                             rsp_err,
  output logic [1:0]                       spi_req,
  output logic [SPI_TRF_BIT-1:0]           spi_din,
  input  logic [SPI_TRF_BIT-1:0]           spi_dout,
  input  logic                             spi_done_tx,
  input  logic                             spi_done_rx,
  input  logic                             spi_idle,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Reject configurations outside the supported range at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("spi_txn_arbiter: parameter out of range");
  end

  arb_state_e              state_r;
  logic [IDX_W-1:0]        last_grant_r;
  spi_mode_e               mode_r;
  logic                    tx_flag_r;
  logic                    rx_flag_r;
  logic [SPI_TRF_BIT-1:0]  rx_data_r;
  logic [7:0]              gap_cnt_r;

  logic [NUM_REQ-1:0]      req_ready_r;
  logic                    rsp_valid_r;
  logic [IDX_W-1:0]        rsp_id_r;
  logic [SPI_TRF_BIT-1:0]  rsp_data_r;
  logic                    rsp_err_r;
  logic [1:0]              spi_req_r;
  logic [SPI_TRF_BIT-1:0]  spi_din_r;
  logic                    busy_r;

  logic [NUM_REQ-1:0]      grant_s;
  logic [IDX_W-1:0]        grant_idx_s;
  logic                    any_req_s;
  logic [SPI_MODE_W-1:0]   mode_bits_s;
  spi_mode_e               mode_sel_s;
  logic [SPI_TRF_BIT-1:0]  data_sel_s;
  logic                    tx_seen_s;
  logic                    rx_seen_s;
  logic                    txn_done_s;
  logic [SPI_TRF_BIT-1:0]  rx_val_s;
  logic                    gap_hit_s;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]         wd_cnt_r;
`endif

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  // Mux the winner's mode and data out of the flat request buses.
  always_comb begin
    any_req_s   = |req_valid;
    mode_bits_s = '0;
    data_sel_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mode_bits_s = mode_bits_s | (req_mode[i*SPI_MODE_W +: SPI_MODE_W] & {SPI_MODE_W{grant_s[i]}});
      data_sel_s  = data_sel_s  | (req_data[i*SPI_TRF_BIT +: SPI_TRF_BIT] & {SPI_TRF_BIT{grant_s[i]}});
    end
    mode_sel_s = spi_mode_e'(mode_bits_s);
  end

  // Completion check: sticky flags or this cycle's strobes satisfy the mode.
  always_comb begin
    tx_seen_s  = tx_flag_r | spi_done_tx;
    rx_seen_s  = rx_flag_r | spi_done_rx;
    txn_done_s = (mode_r != SPI_MODE_NONE) &&
                 (!mode_has_tx(mode_r) || tx_seen_s) &&
                 (!mode_has_rx(mode_r) || rx_seen_s);
    if (spi_done_rx && !rx_flag_r) begin
      rx_val_s = spi_dout;
    end else begin
      rx_val_s = rx_data_r;
    end
    gap_hit_s = ({1'b0, gap_cnt_r} + 9'd1) >= 9'(GAP_CYCLES);
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      mode_r       <= SPI_MODE_NONE;
      tx_flag_r    <= 1'b0;
      rx_flag_r    <= 1'b0;
      rx_data_r    <= '0;
      gap_cnt_r    <= 8'd0;
      req_ready_r  <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_data_r   <= '0;
      rsp_err_r    <= 1'b0;
      spi_req_r    <= 2'd0;
      spi_din_r    <= '0;
      busy_r       <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_cnt_r     <= '0;
`endif
    end else begin
      req_ready_r <= '0;
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s && spi_idle) begin
            state_r <= ARB;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ARB: begin
          if (any_req_s) begin
            req_ready_r  <= grant_s;
            last_grant_r <= grant_idx_s;
            mode_r       <= mode_sel_s;
            tx_flag_r    <= 1'b0;
            rx_flag_r    <= 1'b0;
            gap_cnt_r    <= 8'd0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt_r     <= '0;
`endif
            if (mode_sel_s == SPI_MODE_NONE) begin
              // Illegal mode: answer with an error without touching the master.
              rsp_valid_r <= 1'b1;
              rsp_id_r    <= grant_idx_s;
              rsp_data_r  <= '0;
              rsp_err_r   <= 1'b1;
              state_r     <= GAP;
            end else begin
              spi_req_r   <= mode_sel_s;
              spi_din_r   <= data_sel_s;
              state_r     <= WAIT_DONE;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (txn_done_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= last_grant_r;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= mode_has_rx(mode_r) ? rx_val_s : '0;
            spi_req_r   <= 2'd0;
            tx_flag_r   <= 1'b0;
            rx_flag_r   <= 1'b0;
            gap_cnt_r   <= 8'd0;
            state_r     <= GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // Master never finished: abort and report an error.
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= last_grant_r;
            rsp_err_r   <= 1'b1;
            rsp_data_r  <= '0;
            spi_req_r   <= 2'd0;
            tx_flag_r   <= 1'b0;
            rx_flag_r   <= 1'b0;
            gap_cnt_r   <= 8'd0;
            wd_cnt_r    <= '0;
            state_r     <= GAP;
          end
`endif
          else begin
            if (spi_done_tx) begin
              tx_flag_r <= 1'b1;
            end
            if (spi_done_rx && !rx_flag_r) begin
              rx_flag_r <= 1'b1;
              rx_data_r <= spi_dout;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt_r <= wd_cnt_r + 1'b1;
`endif
          end
        end
        GAP: begin
          if (gap_hit_s) begin
            if (spi_idle) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= GAP;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          spi_req_r <= 2'd0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign spi_req   = spi_req_r;
  assign spi_din   = spi_din_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed, table-driven bench for spi_txn_arbiter (4 requesters, 8-bit
// transfers, 10-cycle gap, 16-cycle watchdog when SPI_ARB_TIMEOUT_EN is set).
module tb_spi_txn_arbiter;

  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int GAP = 10;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [2*NR-1:0] req_mode;
  logic [W*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_err;
  logic [1:0]      spi_req;
  logic [W-1:0]    spi_din;
  logic [W-1:0]    spi_dout;
  logic            spi_done_tx;
  logic            spi_done_rx;
  logic            spi_idle;
  logic            busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .NUM_REQ        (NR),
    .SPI_TRF_BIT    (W),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .spi_req     (spi_req),
    .spi_din     (spi_din),
    .spi_dout    (spi_dout),
    .spi_done_tx (spi_done_tx),
    .spi_done_rx (spi_done_rx),
    .spi_idle    (spi_idle),
    .busy        (busy)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  mode;
    logic [31:0] data;
    logic [7:0]  dout;
    int          dtx;
    int          drx;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_id;
    logic [1:0]  exp_req;
    logic [7:0]  exp_din;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (req_ready == '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int last;
    int cnt;
    int pulses;

    // req_data bytes: r3 r2 r1 r0; req_mode pairs: r3 r2 r1 r0
    vecs[0]  = '{4'b1111, 8'h55, 32'h44332211, 8'h00, 1, 0, 4'b0001, 2'd0, 2'd1, 8'h11, 8'h00, 1'b0};
    vecs[1]  = '{4'b1111, 8'h55, 32'h44332211, 8'h00, 1, 0, 4'b0010, 2'd1, 2'd1, 8'h22, 8'h00, 1'b0};
    vecs[2]  = '{4'b1111, 8'h55, 32'h44332211, 8'h00, 1, 0, 4'b0100, 2'd2, 2'd1, 8'h33, 8'h00, 1'b0};
    vecs[3]  = '{4'b1111, 8'h55, 32'h44332211, 8'h00, 1, 0, 4'b1000, 2'd3, 2'd1, 8'h44, 8'h00, 1'b0};
    vecs[4]  = '{4'b1111, 8'h55, 32'h44332211, 8'h00, 1, 0, 4'b0001, 2'd0, 2'd1, 8'h11, 8'h00, 1'b0};
    vecs[5]  = '{4'b0100, 8'h20, 32'h005A0000, 8'hA5, 0, 1, 4'b0100, 2'd2, 2'd2, 8'h5A, 8'hA5, 1'b0};
    vecs[6]  = '{4'b1000, 8'hC0, 32'h3C000000, 8'h96, 6, 1, 4'b1000, 2'd3, 2'd3, 8'h3C, 8'h96, 1'b0};
    vecs[7]  = '{4'b0010, 8'h00, 32'h0000AB00, 8'h00, 0, 0, 4'b0010, 2'd1, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{4'b0101, 8'hFF, 32'hDEADBEEF, 8'h5C, 2, 2, 4'b0100, 2'd2, 2'd3, 8'hAD, 8'h5C, 1'b0};
    vecs[9]  = '{4'b0011, 8'h06, 32'h00007E81, 8'h42, 2, 3, 4'b0001, 2'd0, 2'd2, 8'h81, 8'h42, 1'b0};
    vecs[10] = '{4'b0010, 8'h04, 32'h00006600, 8'h77, 3, 1, 4'b0010, 2'd1, 2'd1, 8'h66, 8'h00, 1'b0};

    rst = 1'b0; req_valid = '0; req_mode = '0; req_data = '0;
    spi_dout = '0; spi_done_tx = 1'b0; spi_done_rx = 1'b0; spi_idle = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, spi_req, spi_din, busy}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 11; k++) begin
      req_valid = vecs[k].valid;
      req_mode  = vecs[k].mode;
      req_data  = vecs[k].data;
      wait_ready(40, n);
      chk($sformatf("v%0d grant_latency", k), 64'(n), 64'd2);
      chk($sformatf("v%0d req_ready", k), 64'(req_ready), 64'(vecs[k].exp_grant));
      chk($sformatf("v%0d spi_req", k), 64'(spi_req), 64'(vecs[k].exp_req));
      req_valid = '0;
      req_mode  = ~vecs[k].mode;
      req_data  = ~vecs[k].data;
      if (vecs[k].exp_req != 2'd0) begin
        chk($sformatf("v%0d spi_din", k), 64'(spi_din), 64'(vecs[k].exp_din));
        last = (vecs[k].dtx > vecs[k].drx) ? vecs[k].dtx : vecs[k].drx;
        for (int c = 1; c <= last; c++) begin
          spi_done_tx = (c == vecs[k].dtx);
          spi_done_rx = (c == vecs[k].drx);
          spi_dout    = (c == vecs[k].drx) ? vecs[k].dout : ~vecs[k].dout;
          @(negedge clk);
          if (c < last) begin
            chk($sformatf("v%0d early_rsp c%0d", k, c), 64'(rsp_valid), 64'd0);
            chk($sformatf("v%0d din_hold c%0d", k, c), {spi_req, spi_din}, {vecs[k].exp_req, vecs[k].exp_din});
          end
        end
        spi_done_tx = 1'b0;
        spi_done_rx = 1'b0;
        spi_dout    = ~vecs[k].dout;
      end
      chk($sformatf("v%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("v%0d rsp_id", k), 64'(rsp_id), 64'(vecs[k].exp_id));
      chk($sformatf("v%0d rsp_data", k), 64'(rsp_data), 64'(vecs[k].exp_data));
      chk($sformatf("v%0d rsp_err", k), 64'(rsp_err), 64'(vecs[k].exp_err));
      chk($sformatf("v%0d spi_req_after", k), 64'(spi_req), 64'd0);
      @(negedge clk);
      n = 1;
      chk($sformatf("v%0d single_rsp", k), {rsp_valid, spi_req}, 64'd0);
      // stray done strobes during GAP must be ignored
      while (busy && n < 40) begin
        spi_done_tx = 1'b1;
        spi_done_rx = 1'b1;
        @(negedge clk);
        n++;
      end
      spi_done_tx = 1'b0;
      spi_done_rx = 1'b0;
      chk($sformatf("v%0d gap_len", k), 64'(n), 64'(GAP));
    end

    // reset in the middle of WAIT_DONE
    req_valid = 4'b0100; req_mode = 8'h10; req_data = 32'h00550000;
    wait_ready(40, n);
    chk("rst_seq grant", 64'(req_ready), 64'b0100);
    chk("rst_seq spi_req", 64'(spi_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", {req_ready, spi_req, busy}, 64'd0);
    spi_done_tx = 1'b1;
    @(negedge clk);
    chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
    spi_done_tx = 1'b0;
    spi_idle  = 1'b0;
    req_valid = 4'b1111; req_mode = 8'h55; req_data = 32'h44332211;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("idle_gate c%0d", i), {req_ready, busy, rsp_valid}, 64'd0);
    end
    spi_idle = 1'b1;
    wait_ready(40, n);
    chk("post_rst grant", 64'(req_ready), 64'b0001);
    chk("post_rst spi_din", 64'(spi_din), 64'h11);
    req_valid = '0;
    spi_done_tx = 1'b1;
    @(negedge clk);
    spi_done_tx = 1'b0;
    chk("post_rst rsp", {rsp_valid, rsp_id, rsp_err}, {1'b1, 2'd0, 1'b0});
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end

    // outstanding grant: requester keeps asking, master stays silent
    req_valid = 4'b0001; req_mode = 8'h01; req_data = 32'h000000C3;
    wait_ready(40, n);
    chk("wd_seq grant", 64'(req_ready), 64'b0001);
`ifdef SPI_ARB_TIMEOUT_EN
    n = 0;
    pulses = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (|req_ready) pulses++;
    end
    chk("timeout_latency", 64'(n), 64'(TO));
    chk("timeout_rsp", {rsp_err, rsp_id, rsp_data, spi_req}, {1'b1, 2'd0, 8'h00, 2'd0});
    chk("timeout_no_rearb", 64'(pulses), 64'd0);
    wait_ready(100, n);
    chk("timeout_gap_to_grant", 64'(n), 64'(GAP + 2));
    chk("timeout_regrant", 64'(req_ready), 64'b0001);
    req_valid = '0;
    spi_done_tx = 1'b1;
    @(negedge clk);
    spi_done_tx = 1'b0;
    chk("timeout_next_rsp", {rsp_valid, rsp_err}, {1'b1, 1'b0});
`else
    cnt = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
      if (|req_ready) pulses++;
    end
    chk("no_wd_rsp", 64'(cnt), 64'd0);
    chk("no_wd_rearb", 64'(pulses), 64'd0);
    chk("no_wd_spi_req", 64'(spi_req), 64'd1);
    req_valid = '0;
    spi_done_tx = 1'b1;
    @(negedge clk);
    spi_done_tx = 1'b0;
    chk("no_wd_late_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 8'h00});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one SPI master (2..8).
REQ-002 SHALL have parameter SPI_TRF_BIT, default 8, bits per SPI transfer.
REQ-003 SHALL have parameter GAP_CYCLES, default 10, minimum idle clk cycles between transactions (0..255).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit in clk cycles (used only under SPI_ARB_TIMEOUT_EN).
REQ-005 SHALL have port clk, input, 1, sole clock, all state on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester transaction request.
REQ-008 SHALL have port req_mode, input, 2*NUM_REQ, per-requester mode: 0 none, 1 TX (MOSI), 2 RX (MISO), 3 full duplex.
REQ-009 SHALL have port req_data, input, SPI_TRF_BIT*NUM_REQ, per-requester data to transmit.
REQ-010 SHALL have port req_ready, output, NUM_REQ, one-hot, one-cycle pulse accepting the winner's request.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rsp_id, output, $clog2(NUM_REQ), index of the completed requester.
REQ-013 SHALL have port rsp_data, output, SPI_TRF_BIT, data received from the SPI master.
REQ-014 SHALL have port rsp_err, output, 1, marks an illegal-mode or timed-out transaction (qualified by rsp_valid).
REQ-015 SHALL have ports spi_req (output, 2), spi_din (output, SPI_TRF_BIT), spi_dout (input, SPI_TRF_BIT), spi_done_tx (input, 1), spi_done_rx (input, 1) and spi_idle (input, 1, master TX and RX FSMs both idle).
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, ARB, WAIT_DONE and GAP.
REQ-018 IDLE SHALL go to ARB when any req_valid bit is high and spi_idle=1, and SHALL stay in IDLE otherwise.
REQ-019 ARB SHALL pick the winner round-robin, starting the search at last_grant+1 modulo NUM_REQ.
REQ-020 In ARB, the winner's req_ready SHALL pulse for one cycle, and its mode and data SHALL be captured into internal registers.
REQ-021 ARB SHALL update last_grant to the winner.
REQ-022 ARB SHALL fall back to IDLE with no pulse if every req_valid has dropped.
REQ-023 If the captured mode is 0, the next cycle SHALL give rsp_valid=1 and rsp_err=1 with rsp_data=0, and the FSM SHALL enter GAP without driving spi_req.
REQ-024 WAIT_DONE SHALL drive spi_req=captured mode and spi_din=captured data, held stable for the whole state.
REQ-025 WAIT_DONE SHALL latch sticky flags for spi_done_tx and spi_done_rx.
REQ-026 Completion SHALL require: mode 1, the tx flag; mode 2, the rx flag; mode 3, both flags, in either order or in the same cycle.
REQ-027 On completion, the next cycle SHALL give rsp_valid=1 with rsp_id=winner and rsp_err=0.
REQ-028 On completion, rsp_data SHALL be the spi_dout value sampled on the rx-done cycle for modes 2 and 3, and SHALL be 0 for mode 1.
REQ-029 After completion, spi_req SHALL go to 0, the done flags SHALL clear, and the FSM SHALL enter GAP.
REQ-030 GAP SHALL count GAP_CYCLES and SHALL exit to IDLE only once the count is reached and spi_idle=1.
REQ-031 With GAP_CYCLES=0, GAP SHALL last exactly one cycle.
REQ-032 Transaction latency SHALL be 1 cycle from the ARB entry edge to spi_req valid.
REQ-033 Transaction latency SHALL be 1 cycle from the final done to rsp_valid.
REQ-034 The block SHALL NOT re-arbitrate while a grant is outstanding.
REQ-035 req_valid changes after the req_ready pulse SHALL NOT affect the granted transaction.
REQ-036 A done pulse that arrives outside WAIT_DONE SHALL be ignored.

Reset
REQ-037 rst low SHALL force, immediately and asynchronously, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), and all flags and counters to 0.
REQ-038 rst low SHALL force these outputs to 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, spi_req, spi_din and busy.
REQ-039 Reset mid-transaction SHALL drop spi_req to 0 without producing rsp_valid.

Configuration
REQ-040 With macro SPI_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_DONE.
REQ-041 With SPI_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL force spi_req=0 and give rsp_valid=1 with rsp_err=1 and rsp_data=0, then the FSM SHALL enter GAP.
REQ-042 Without SPI_ARB_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, no watchdog logic SHALL be present, and rsp_err SHALL flag only illegal mode.

Structure
REQ-043 Package spi_arb_pkg SHALL hold the state enum (IDLE, ARB, WAIT_DONE, GAP) and the mode typedef (SPI_MODE_NONE=0, SPI_MODE_TX=1, SPI_MODE_RX=2, SPI_MODE_FD=3).
REQ-044 spi_arb_pkg SHALL hold the mode-width constant (2).
REQ-045 The round-robin pick logic SHALL be a combinational sub-module, spi_rr_arbiter, with inputs req vector and last_grant and outputs a one-hot grant and an index.

Verification
REQ-046 SHALL cover: after reset, req_valid=4'b1111 with all modes 1 -> grants in order 0,1,2,3,0, each rsp_err=0.
REQ-047 SHALL cover: requester 2 mode 2, spi_dout=8'hA5 with spi_done_rx -> rsp_id=2, rsp_data=8'hA5 one cycle after done.
REQ-048 SHALL cover: mode 3 with done_rx 5 cycles before done_tx -> exactly one rsp_valid, one cycle after done_tx; spi_din held at 8'h3C throughout.
REQ-049 SHALL cover: requester 1 mode 0 -> req_ready[1] pulse, then rsp_valid=1 with rsp_err=1, and spi_req stays 0.
REQ-050 SHALL cover: rst low in WAIT_DONE -> spi_req=0 immediately, no rsp_valid, requester 0 wins the next arbitration.
REQ-051 SHALL cover: with SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no done -> rsp_err=1 after 16 cycles, then GAP lasts at least 10 cycles before the next grant.
